microwave_ctrl: RTL and testbench
=================================

# microwave_ctrl

Front-panel controller for the microwave oven: collects keypad digits into a mm:ss cook time, loads it into the countdown timer, generates the 1 Hz count-enable tick, and drives magnetron and lamp outputs. Pauses on door open or stop, and raises a done indication when the timer reports zero. Sits between the keypad/door sensors and the timer chain (ones/tens/minutes digits).

## Interface
- TICK_DIV, 50_000_000: clock cycles per timer tick (1 s); minimum 4.
- BEEP_CYCLES, 25_000_000: beep pulse length in cycles; used only with MW_DONE_BEEP_EN.

- clock  in  1  system clock, all state on rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  4  0–9 digit; 10–15 ignored.
- start  in  1  start/resume request, level sampled each cycle.
- stop  in  1  pause/cancel request.
- door_open  in  1  door sensor, 1 = open.
- tmr_zero  in  1  timer all-digits-zero flag.
- set_mins, set_tens, set_ones  out  4 each  entered time, BCD.
- tmr_load  out  1  one-cycle load strobe to timer.
- tmr_en  out  1  one-cycle count-down enable (tick).
- tmr_clr  out  1  one-cycle timer clear strobe.
- mag_on  out  1  magnetron enable.
- light_on  out  1  lamp; combinational door_open | mag_on.
- done  out  1  cook complete, level.
- beep  out  1  done beep (MW_DONE_BEEP_EN only; else tied 0).
- state  out  3  current FSM state, debug.

## Operation
- States: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4; codes 5–7 unreachable, map to IDLE.
- Priority per cycle: stop > door_open > start > key_valid.
- IDLE: digits 0. key_valid with digit d → set_ones=d, → ENTRY.
- ENTRY: each digit shifts left: mins←tens, tens←ones, ones←d; fourth digit drops oldest. On load, set_tens saturates to 5 if >5. start with door closed and digits ≠ 000 → tmr_load, → COOK. start with door open or 000 entry ignored. stop → digits cleared, tmr_clr, → IDLE.
- COOK: mag_on=1; prescaler runs; tmr_en pulses once per TICK_DIV cycles. tmr_zero ignored for the 2 cycles after tmr_load (timer settle guard), then tmr_zero=1 → mag_on=0, done=1, → DONE. stop or door_open → PAUSE.
- PAUSE: mag_on=0, tmr_en=0, prescaler holds count. start with door closed → COOK, prescaler resumes from held value. stop → tmr_clr, digits cleared, → IDLE.
- DONE: done=1. key_valid, stop, or door_open → done=0, digits cleared, → IDLE. start ignored.
- key_valid outside IDLE/ENTRY ignored.

## Timing
- Reset: state IDLE; all registered outputs 0; prescaler 0.
- All outputs except light_on are registered.
- start accepted at edge N → tmr_load=1 and mag_on=1 during cycle N+1; tmr_load low at N+2.
- First tmr_en at TICK_DIV cycles after COOK entry; tmr_en never high in the same cycle as tmr_load.
- stop/door_open in COOK → mag_on low 1 cycle later; a tick due that same cycle is suppressed.
- tmr_zero seen at edge M → done=1, mag_on=0 from M+1.
- Reset mid-COOK: mag_on drops immediately (asynchronous), no tmr_clr issued.

## Configuration
- MW_DONE_BEEP_EN defined: on DONE entry, beep=1 for exactly BEEP_CYCLES cycles, then 0; leaving DONE early clears beep at once.
- Undefined: beep constant 0, no beep counter synthesized; done behaviour unchanged.

## Structure
- Package mw_pkg: state encoding constants, KEY_DIGIT_MAX=9, TENS_MAX=5, state width 3.
- Sub-module mw_prescaler: counter 0..TICK_DIV-1 with run, clear inputs and tick output; count held while run=0.
- Beep counter inline, inside MW_DONE_BEEP_EN guard.

## Test plan (TICK_DIV=4, BEEP_CYCLES=3)
- Keys 1,3,0 then start, door closed → set_mins=1, set_tens=3, set_ones=0; tmr_load one cycle after start; mag_on=1; tmr_en every 4 cycles.
- Keys 1,2,3,4 → set 2/3/4; keys 9,9 then start → set_tens loaded as 5, set_ones 9.
- COOK, door_open for 10 cycles then close and start → mag_on 0 during pause, light_on 1, no tmr_en; tick resumes from held prescaler count.
- COOK, tmr_zero=1 → done=1, mag_on=0 next cycle; with macro beep high exactly 3 cycles; key_valid → IDLE, done=0.
- start with digits 000, or with door_open=1 → state stays ENTRY/IDLE, no tmr_load.
- stop and start same cycle in PAUSE → tmr_clr pulse, state IDLE, digits 0.

Source files
------------

// File: rtl/mw_pkg.sv
// Shared definitions for the microwave front-panel controller.
package mw_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 3'd0,
    StEntry = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } mw_state_e;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX      = 4'd5;

  function automatic logic [3:0] sat_tens(input logic [3:0] tens);
    return (tens > TENS_MAX) ? TENS_MAX : tens;
  endfunction

endpackage

// File: rtl/mw_prescaler.sv
// Cook-tick prescaler: counts 0..TICK_DIV-1 while run is high, holds otherwise.
module mw_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic clrn,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CntW   = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = run && (cnt_q == CntMax);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave front-panel controller: keypad entry, cook/pause/done sequencing, tick generation.
// Optional done beep is built when MW_DONE_BEEP_EN is defined.
module microwave_ctrl
  import mw_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned BEEP_CYCLES = 25_000_000
) (
  input  logic                clock,
  input  logic                clrn,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                start,
  input  logic                stop,
  input  logic                door_open,
  input  logic                tmr_zero,
  output logic [3:0]          set_mins,
  output logic [3:0]          set_tens,
  output logic [3:0]          set_ones,
  output logic                tmr_load,
  output logic                tmr_en,
  output logic                tmr_clr,
  output logic                mag_on,
  output logic                light_on,
  output logic                done,
  output logic                beep,
  output logic [STATE_W-1:0]  state
);

  localparam int unsigned BeepW     = $clog2(BEEP_CYCLES + 1);
  localparam logic [1:0]  LoadGuard = 2'd2;

  typedef logic [BeepW-1:0] beep_cnt_t;

  mw_state_e  state_q;
  logic [1:0] guard_q;
  logic       key_digit;
  logic       entry_nz;
  logic       zero_seen;
  logic       enter_done;
  logic       leave_done;
  logic       cook_run;
  logic       presc_clr;
  logic       tick;

  assign key_digit  = key_valid && (key_code <= KEY_DIGIT_MAX);
  assign entry_nz   = |{set_mins, set_tens, set_ones};
  // The timer's zero flag is stale until the load has settled.
  assign zero_seen  = tmr_zero && (guard_q == 2'd0);
  assign enter_done = (state_q == StCook) && !stop && !door_open && zero_seen;
  assign leave_done = (state_q == StDone) && (stop || door_open || (key_valid && !start));
  assign cook_run   = (state_q == StCook) && !stop && !door_open && !zero_seen;
  assign presc_clr  = (state_q != StCook) && (state_q != StPause);
  assign light_on   = door_open | mag_on;
  assign state      = state_q;

  mw_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .clrn  (clrn),
    .run   (cook_run),
    .clear (presc_clr),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q                          <= StIdle;
      {set_mins, set_tens, set_ones}   <= '0;
      tmr_load                         <= 1'b0;
      tmr_en                           <= 1'b0;
      tmr_clr                          <= 1'b0;
      mag_on                           <= 1'b0;
      done                             <= 1'b0;
      guard_q                          <= '0;
    end else begin
      tmr_load <= 1'b0;
      tmr_en   <= 1'b0;
      tmr_clr  <= 1'b0;
      if (guard_q != 2'd0) guard_q <= guard_q - 2'd1;
      case (state_q)
        StIdle: begin
          if (!stop && !door_open && !start && key_digit) begin
            set_ones <= key_code;
            state_q  <= StEntry;
          end
        end
        StEntry: begin
          if (stop) begin
            {set_mins, set_tens, set_ones} <= '0;
            tmr_clr <= 1'b1;
            state_q <= StIdle;
          end else if (!door_open && start) begin
            if (entry_nz) begin
              set_tens <= sat_tens(set_tens);
              tmr_load <= 1'b1;
              mag_on   <= 1'b1;
              guard_q  <= LoadGuard;
              state_q  <= StCook;
            end
          end else if (!door_open && key_digit) begin
            set_mins <= set_tens;
            set_tens <= set_ones;
            set_ones <= key_code;
          end
        end
        StCook: begin
          if (stop || door_open) begin
            mag_on  <= 1'b0;
            state_q <= StPause;
          end else if (enter_done) begin
            mag_on  <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            tmr_en <= tick;
          end
        end
        StPause: begin
          if (stop) begin
            {set_mins, set_tens, set_ones} <= '0;
            tmr_clr <= 1'b1;
            state_q <= StIdle;
          end else if (!door_open && start) begin
            mag_on  <= 1'b1;
            state_q <= StCook;
          end
        end
        StDone: begin
          if (leave_done) begin
            {set_mins, set_tens, set_ones} <= '0;
            done    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          {set_mins, set_tens, set_ones} <= '0;
          mag_on  <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef MW_DONE_BEEP_EN
  beep_cnt_t beep_cnt_q;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      beep       <= 1'b0;
      beep_cnt_q <= '0;
    end else if (enter_done) begin
      beep       <= 1'b1;
      beep_cnt_q <= beep_cnt_t'(BEEP_CYCLES - 1);
    end else if ((state_q != StDone) || leave_done || (beep_cnt_q == '0)) begin
      beep <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_q - beep_cnt_t'(1);
    end
  end
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_ctrl.sv
// Randomized self-checking bench for microwave_ctrl against a cycle-level behavioural model.
module tb_microwave_ctrl;

  localparam int TickDiv    = 4;
  localparam int BeepCycles = 3;
`ifdef MW_DONE_BEEP_EN
  localparam bit BeepOn = 1'b1;
`else
  localparam bit BeepOn = 1'b0;
`endif

  localparam int SIdle  = 0;
  localparam int SEntry = 1;
  localparam int SCook  = 2;
  localparam int SPause = 3;
  localparam int SDone  = 4;

  logic       clock = 1'b0;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       stop;
  logic       door_open;
  logic       tmr_zero;
  logic [3:0] set_mins;
  logic [3:0] set_tens;
  logic [3:0] set_ones;
  logic       tmr_load;
  logic       tmr_en;
  logic       tmr_clr;
  logic       mag_on;
  logic       light_on;
  logic       done;
  logic       beep;
  logic [2:0] state;

  microwave_ctrl #(
    .TICK_DIV    (TickDiv),
    .BEEP_CYCLES (BeepCycles)
  ) dut (
    .clock     (clock),
    .clrn      (clrn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .start     (start),
    .stop      (stop),
    .door_open (door_open),
    .tmr_zero  (tmr_zero),
    .set_mins  (set_mins),
    .set_tens  (set_tens),
    .set_ones  (set_ones),
    .tmr_load  (tmr_load),
    .tmr_en    (tmr_en),
    .tmr_clr   (tmr_clr),
    .mag_on    (mag_on),
    .light_on  (light_on),
    .done      (done),
    .beep      (beep),
    .state     (state)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: the entry is kept as a decimal number 0..999 (mm:ss as digits m,t,o).
  int m_state, m_entry, m_since_load, m_active, m_beep_left;
  bit m_load, m_en, m_clr, m_mag, m_done, m_beep;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = SIdle; m_entry = 0; m_since_load = 100; m_active = 0; m_beep_left = 0;
    m_load = 0; m_en = 0; m_clr = 0; m_mag = 0; m_done = 0; m_beep = 0;
  endtask

  // Advance the model across one rising edge using the inputs now being driven.
  task automatic model_step();
    int top;
    int tens;
    m_load = 0; m_en = 0; m_clr = 0;
    m_since_load++;
    top = stop ? 4 : door_open ? 3 : start ? 2 : key_valid ? 1 : 0;
    case (m_state)
      SIdle: if (top == 1 && key_code <= 9) begin
        m_entry = int'(key_code);
        m_state = SEntry;
      end
      SEntry: begin
        if (top == 4) begin
          m_entry = 0; m_clr = 1; m_state = SIdle;
        end else if (top == 2) begin
          if (m_entry != 0) begin
            tens = (m_entry / 10) % 10;
            if (tens > 5) tens = 5;
            m_entry = (m_entry / 100) * 100 + tens * 10 + m_entry % 10;
            m_load = 1; m_mag = 1; m_since_load = 0; m_active = 0; m_state = SCook;
          end
        end else if (top == 1 && key_code <= 9) begin
          m_entry = (m_entry * 10 + int'(key_code)) % 1000;
        end
      end
      SCook: begin
        if (stop || door_open) begin
          m_mag = 0; m_state = SPause;
        end else if (tmr_zero && m_since_load > 2) begin
          m_mag = 0; m_done = 1; m_state = SDone; m_beep_left = BeepCycles;
        end else begin
          m_active++;
          m_en = (m_active % TickDiv) == 0;
        end
      end
      SPause: begin
        if (top == 4) begin
          m_entry = 0; m_clr = 1; m_state = SIdle;
        end else if (top == 2) begin
          m_mag = 1; m_state = SCook;
        end
      end
      SDone: begin
        if (top == 4 || top == 3 || top == 1) begin
          m_entry = 0; m_done = 0; m_state = SIdle; m_beep_left = 0;
        end else if (m_beep_left > 0) begin
          m_beep_left--;
        end
      end
      default: m_state = SIdle;
    endcase
    m_beep = BeepOn && (m_state == SDone) && (m_beep_left > 0);
  endtask

  task automatic check_all();
    check("state",    32'(state),    32'(m_state));
    check("set_mins", 32'(set_mins), 32'(m_entry / 100));
    check("set_tens", 32'(set_tens), 32'((m_entry / 10) % 10));
    check("set_ones", 32'(set_ones), 32'(m_entry % 10));
    check("tmr_load", 32'(tmr_load), 32'(m_load));
    check("tmr_en",   32'(tmr_en),   32'(m_en));
    check("tmr_clr",  32'(tmr_clr),  32'(m_clr));
    check("mag_on",   32'(mag_on),   32'(m_mag));
    check("light_on", 32'(light_on), 32'(door_open | m_mag));
    check("done",     32'(done),     32'(m_done));
    check("beep",     32'(beep),     32'(m_beep));
  endtask

  task automatic apply(input logic kv, input logic [3:0] kc, input logic st, input logic sp,
                       input logic dr, input logic tz);
    @(negedge clock);
    check_all();
    key_valid = kv; key_code = kc; start = st; stop = sp; door_open = dr; tmr_zero = tz;
    model_step();
  endtask

  task automatic key(input int d);
    apply(1'b1, 4'(d), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    key_valid = 0; key_code = 0; start = 0; stop = 0; door_open = 0; tmr_zero = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    clrn = 1'b1;
    model_step();
  endtask

  initial begin
    logic kv, st, sp, dr, tz;
    logic [3:0] kc;
    do_reset();

    // 1,3,0 then start; watch the ticks.
    key(1); key(3); key(0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    // Door pause, then close and resume.
    for (int i = 0; i < 10; i++) apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    // Timer reaches zero, beep window, then a key returns to idle.
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    key(7);
    idle(2);
    // Four digits drop the oldest; pause then stop+start together.
    key(1); key(2); key(3); key(4);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Tens saturation on load, with zero flag inside the settle window.
    key(9); key(9);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Rejected starts: 000 entry, then door open.
    key(0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    key(5);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    dr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      kv = ($urandom_range(0, 3) == 0);
      kc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 39) == 0);
      if (dr) dr = ($urandom_range(0, 7) != 0);
      else    dr = ($urandom_range(0, 59) == 0);
      tz = ($urandom_range(0, 24) == 0);
      apply(kv, kc, st, sp, dr, tz);
    end

    // Asynchronous reset while cooking.
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    key(4);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    @(negedge clock);
    check_all();
    check("cook_before_rst", 32'(mag_on), 32'd1);
    #2 clrn = 1'b0;
    #1;
    check("rst_mag_on",  32'(mag_on),  32'd0);
    check("rst_tmr_clr", 32'(tmr_clr), 32'd0);
    check("rst_state",   32'(state),   32'(SIdle));
    do_reset();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
